calc2_req_issuer: RTL

CALC2_REQ_ISSUER -- requirements
Module: calc2_req_issuer

---
 rtl/calc2_pkg.sv | 36 +++
 rtl/calc2_tag_pool.sv | 80 ++++++++
 rtl/calc2_req_issuer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/calc2_pkg.sv
// rtl/calc2_pkg.sv - shared encodings, sizes and FSM state type for the calc2 request issuer
package calc2_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_ADD = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_SHL = 4'b0101;
    localparam logic [3:0] CMD_SHR = 4'b0110;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_OVF  = 2'b10;
    localparam logic [1:0] RESP_INV  = 2'b11;

    localparam int TAG_W         = 2;
    localparam int NUM_TAGS      = 4;
    localparam int TIMEOUT_LIMIT = 255;
    localparam int AGE_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_OP1,
        ST_SEND_OP2
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [TAG_W-1:0] lowest_set(input logic [NUM_TAGS-1:0] v);
        logic [TAG_W-1:0] r;
        r = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (v[i]) r = i[TAG_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/calc2_tag_pool.sv
// rtl/calc2_tag_pool.sv - busy bitmap, lowest-free tag allocator and optional age timeouts (CALC2_TIMEOUT_EN)
module calc2_tag_pool
    import calc2_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic                free_en,
    input  logic [TAG_W-1:0]    free_tag,
    input  logic                to_take,
    output logic [TAG_W-1:0]    alloc_tag,
    output logic                any_free,
    output logic [NUM_TAGS-1:0] busy,
    output logic                to_valid,
    output logic [TAG_W-1:0]    to_tag
);

    logic [NUM_TAGS-1:0] alloc_mask;
    logic [NUM_TAGS-1:0] free_mask;
    logic [NUM_TAGS-1:0] to_hit;

    assign alloc_tag  = lowest_set(~busy);
    assign any_free   = ~&busy;
    assign alloc_mask = alloc_en ? (NUM_TAGS'(1) << alloc_tag) : '0;
    assign free_mask  = free_en ? (NUM_TAGS'(1) << free_tag) : '0;

    // Allocation only ever targets a tag that is free in the registered map,
    // so freeing a different tag in the same cycle never collides with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~free_mask & ~to_hit) | alloc_mask;
        end
    end

`ifdef CALC2_TIMEOUT_EN
    logic [AGE_W-1:0]    age [NUM_TAGS];
    logic [NUM_TAGS-1:0] to_pend;
    logic [NUM_TAGS-1:0] to_cand;
    logic [NUM_TAGS-1:0] to_sel;

    // A real response on the same tag wins; the expiring timeout is dropped.
    always_comb begin
        to_hit = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            to_hit[i] = busy[i] && (age[i] == AGE_W'(TIMEOUT_LIMIT)) && !free_mask[i];
        end
    end

    assign to_cand  = to_pend | to_hit;
    assign to_valid = |to_cand;
    assign to_tag   = lowest_set(to_cand);
    assign to_sel   = (to_take && to_valid) ? (NUM_TAGS'(1) << to_tag) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_pend <= '0;
            for (int i = 0; i < NUM_TAGS; i++) age[i] <= '0;
        end else begin
            to_pend <= to_cand & ~to_sel;
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (alloc_mask[i]) begin
                    age[i] <= '0;
                end else if (busy[i] && age[i] != AGE_W'(TIMEOUT_LIMIT)) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end
`else
    logic unused_to_take;

    assign unused_to_take = to_take;
    assign to_hit         = '0;
    assign to_valid       = 1'b0;
    assign to_tag         = '0;
`endif

endmodule

// File: rtl/calc2_req_issuer.sv
// rtl/calc2_req_issuer.sv - two-beat calculator request issuer with tagged completions; CALC2_TIMEOUT_EN adds tag timeouts
module calc2_req_issuer
    import calc2_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [0:3]  host_cmd,
    input  logic [0:31] host_data1,
    input  logic [0:31] host_data2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    output logic [0:1]  req_tag_out,
    input  logic [0:1]  out_resp,
    input  logic [0:1]  out_tag,
    input  logic [0:31] out_data,
    output logic        cmpl_valid,
    output logic [0:1]  cmpl_resp,
    output logic [0:1]  cmpl_tag,
    output logic [0:31] cmpl_data,
    output logic        cmpl_timeout,
    output logic        err_spurious
);

    state_t              state;
    logic [0:31]         data2_q;
    logic [TAG_W-1:0]    alloc_tag;
    logic                any_free;
    logic [NUM_TAGS-1:0] busy;
    logic                to_valid;
    logic [TAG_W-1:0]    to_tag;
    logic                accept;
    logic                resp_hit;

    // Gated by reset so the host sees not-ready throughout reset, ready right after.
    assign host_ready = !reset && (state == ST_IDLE) && any_free;
    assign accept     = host_valid && host_ready;
    assign resp_hit   = (out_resp != RESP_NONE);

    calc2_tag_pool u_tag_pool (
        .clk       (c_clk),
        .rst       (reset),
        .alloc_en  (accept),
        .free_en   (resp_hit),
        .free_tag  (out_tag),
        .to_take   (!resp_hit),
        .alloc_tag (alloc_tag),
        .any_free  (any_free),
        .busy      (busy),
        .to_valid  (to_valid),
        .to_tag    (to_tag)
    );

    // Beat 1 is loaded on the accepting edge so it appears one cycle after acceptance.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_cmd_out  <= CMD_NOP;
            req_data_out <= '0;
            req_tag_out  <= '0;
            data2_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_SEND_OP1;
                        req_cmd_out  <= host_cmd;
                        req_data_out <= host_data1;
                        req_tag_out  <= alloc_tag;
                        data2_q      <= host_data2;
                    end else begin
                        req_cmd_out  <= CMD_NOP;
                        req_data_out <= '0;
                        req_tag_out  <= '0;
                    end
                end
                ST_SEND_OP1: begin
                    state        <= ST_SEND_OP2;
                    req_cmd_out  <= CMD_NOP;
                    req_data_out <= data2_q;
                end
                ST_SEND_OP2: begin
                    state        <= ST_IDLE;
                    req_cmd_out  <= CMD_NOP;
                    req_data_out <= '0;
                    req_tag_out  <= '0;
                end
                default: begin
                    state        <= ST_IDLE;
                    req_cmd_out  <= CMD_NOP;
                    req_data_out <= '0;
                    req_tag_out  <= '0;
                end
            endcase
        end
    end

    // Real responses take priority; a pending timeout waits in the pool.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cmpl_valid   <= 1'b0;
            cmpl_resp    <= RESP_NONE;
            cmpl_tag     <= '0;
            cmpl_data    <= '0;
            err_spurious <= 1'b0;
        end else if (resp_hit) begin
            cmpl_valid <= 1'b1;
            cmpl_resp  <= out_resp;
            cmpl_tag   <= out_tag;
            cmpl_data  <= out_data;
            if (!busy[out_tag]) err_spurious <= 1'b1;
        end else if (to_valid) begin
            cmpl_valid <= 1'b1;
            cmpl_resp  <= RESP_NONE;
            cmpl_tag   <= to_tag;
            cmpl_data  <= '0;
        end else begin
            cmpl_valid <= 1'b0;
        end
    end

`ifdef CALC2_TIMEOUT_EN
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cmpl_timeout <= 1'b0;
        end else begin
            cmpl_timeout <= !resp_hit && to_valid;
        end
    end
`else
    assign cmpl_timeout = 1'b0;
`endif

endmodule
